decoder_seq: RTL and testbench



---
 rtl/decoder_seq.sv | 119 +++++++++++
 tb/tb_decoder_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq
// Brief    : Registered binary-to-one-hot decoder with output enable, a
//            valid/ready load port and an optional auto-scan mode enabled
//            by the DECODER_SEQ_SCAN_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    s_valid,
    input  logic [SEL_W-1:0]        s,
    output logic                    s_ready,
    input  logic                    scan,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   x,
    output logic [SEL_W-1:0]        cur,
    output logic                    wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] c_idx_max = SEL_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] c_one     = OUT_W'(1);

    logic               r_s_ready;
    logic [SEL_W-1:0]   r_cur;
    logic [OUT_W-1:0]   r_x;
    logic               w_load;
    logic [SEL_W-1:0]   w_cur_next;
    logic [OUT_W-1:0]   w_x_next;

    assign w_load   = s_valid & r_s_ready;
    assign w_x_next = en ? (c_one << w_cur_next) : '0;

`ifdef DECODER_SEQ_SCAN_EN

    typedef enum logic [0:0] {
        ST_STATIC = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_next;
    logic               r_wrap;
    logic               w_wrap_next;

    // A load always wins over a scan step; the counter restarts from dwell
    // whenever it is not actively counting down in SCAN.
    always_comb begin
        w_cur_next   = w_load ? s : r_cur;
        w_cnt_next   = dwell;
        w_wrap_next  = 1'b0;
        w_state_next = scan ? ST_SCAN : ST_STATIC;
        if (r_state == ST_SCAN && scan && !w_load) begin
            if (r_cnt == '0) begin
                w_cur_next  = r_cur + SEL_W'(1);
                w_wrap_next = (r_cur == c_idx_max);
            end else begin
                w_cnt_next  = r_cnt - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_STATIC;
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
            r_cur     <= '0;
            r_x       <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_wrap    <= w_wrap_next;
            r_cur     <= w_cur_next;
            r_x       <= w_x_next;
            r_s_ready <= 1'b1;
        end
    end

    assign wrap = r_wrap;

`else

    logic w_unused_scan;

    assign w_unused_scan = ^{scan, dwell};
    assign w_cur_next    = w_load ? s : r_cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur     <= '0;
            r_x       <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_cur     <= w_cur_next;
            r_x       <= w_x_next;
            r_s_ready <= 1'b1;
        end
    end

    assign wrap = 1'b0;

`endif

    assign s_ready = r_s_ready;
    assign cur     = r_cur;
    assign x       = r_x;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_seq
// Brief    : Self-checking bench for decoder_seq against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;
    localparam int OUT_W   = 2**SEL_W;
`ifdef DECODER_SEQ_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               s_valid = 1'b0;
    logic [SEL_W-1:0]   s = '0;
    logic               s_ready;
    logic               scan = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [OUT_W-1:0]   x;
    logic [SEL_W-1:0]   cur;
    logic               wrap;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s(s),
        .s_ready(s_ready), .scan(scan), .dwell(dwell), .x(x), .cur(cur),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: index, remaining dwell, mode and the derived outputs.
    int m_cur = 0, m_cnt = 0, m_x = 0;
    bit m_scan = 0, m_ready = 0, m_wrap = 0;

    always @(posedge clk) begin
        bit ld;
        int ncur;
        if (!rst_n) begin
            m_cur = 0; m_cnt = 0; m_scan = 0; m_ready = 0; m_wrap = 0; m_x = 0;
        end else begin
            ld     = s_valid && m_ready;
            ncur   = m_cur;
            m_wrap = 0;
            if (SCAN_EN && m_scan && scan) begin
                if (ld) begin
                    ncur  = int'(s);
                    m_cnt = int'(dwell);
                end else if (m_cnt == 0) begin
                    ncur   = (m_cur + 1) % OUT_W;
                    m_wrap = (m_cur == OUT_W - 1);
                    m_cnt  = int'(dwell);
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                if (ld) ncur = int'(s);
                m_cnt = int'(dwell);
            end
            m_scan  = SCAN_EN && scan;
            m_cur   = ncur;
            m_x     = en ? (1 << ncur) : 0;
            m_ready = 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_x",     int'(x),       m_x);
            check("model_cur",   int'(cur),     m_cur);
            check("model_ready", int'(s_ready), int'(m_ready));
            check("model_wrap",  int'(wrap),    int'(m_wrap));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int prev;
        repeat (3) step();
        check("reset_x", int'(x), 0);
        check("reset_ready", int'(s_ready), 0);
        chk_on = 1'b1;

        rst_n = 1'b1; en = 1'b1;
        step();
        check("post_reset_x", int'(x), 8'h01);
        check("post_reset_cur", int'(cur), 0);
        check("post_reset_ready", int'(s_ready), 1);

        // Static loads of every index.
        for (int i = 0; i < OUT_W; i++) begin
            s_valid = 1'b1; s = SEL_W'(i);
            step();
            check("static_load_x", int'(x), 1 << i);
            check("static_load_cur", int'(cur), i);
        end
        s_valid = 1'b0;
        prev = int'(cur);
        en = 1'b0;
        step();
        check("blank_x", int'(x), 0);
        check("blank_cur", int'(cur), prev);
        en = 1'b1;
        step();
        check("unblank_x", int'(x), 1 << prev);

        // Scan with dwell=2 starting at index 6.
        s_valid = 1'b1; s = 3'd6;
        step();
        s_valid = 1'b0; scan = 1'b1; dwell = 4'd2;
        step();
        if (SCAN_EN) begin
            check("scan_hold6_a", int'(cur), 6);
            step(); check("scan_hold6_b", int'(cur), 6);
            step(); check("scan_hold6_c", int'(cur), 6);
            for (int i = 0; i < 3; i++) begin
                step();
                check("scan_hold7", int'(cur), 7);
                check("scan_nowrap7", int'(wrap), 0);
            end
            step();
            check("scan_wrap_cur", int'(cur), 0);
            check("scan_wrap", int'(wrap), 1);
            check("scan_wrap_x", int'(x), 8'h01);
            step();
            check("scan_wrap_pulse", int'(wrap), 0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                step();
                check("noscan_cur", int'(cur), 6);
                check("noscan_wrap", int'(wrap), 0);
            end
        end

        // Reset in the middle of scanning.
        rst_n = 1'b0;
        step();
        check("midrst_cur", int'(cur), 0);
        check("midrst_x", int'(x), 0);
        check("midrst_wrap", int'(wrap), 0);
        check("midrst_ready", int'(s_ready), 0);
        rst_n = 1'b1;
        step();
        check("midrst_release_ready", int'(s_ready), 1);
        check("midrst_release_cur", int'(cur), 0);

        // Randomised traffic, compared every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            en      = ($urandom_range(0, 7) != 0);
            s_valid = ($urandom_range(0, 3) == 0);
            s       = SEL_W'($urandom_range(0, OUT_W - 1));
            if ($urandom_range(0, 39) == 0) scan = ~scan;
            if ($urandom_range(0, 19) == 0) dwell = DWELL_W'($urandom_range(0, 3));
            step();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
